ledkey_io_ctrl: RTL
===================

// Module: ledkey_io_ctrl
// PURPOSE
//  CPU-side controller for the LED&KEY panel. Sits between the SBC6502 I/O bus and tm1638_driver:
//  - holds the LED, dot and digit bitmaps written by the 6502;
//  - debounces the eight raw buttons and queues press/release events in a FIFO;
//  - raises an active-low IRQ_ when an event is pending.
// PARAMETERS
//  SYSCLK_MHZ     27  clock frequency in MHz; sets the 1 ms debounce tick (SYSCLK_MHZ*1000 cycles)
//  DEBOUNCE_MS    10  consecutive ms ticks a raw key must differ from stable before it is accepted (1..15)
//  FIFO_DEPTH     8   event FIFO entries (power of 2, 2..16)
// PORTS
//  CLK        in   1   system clock
//  RESET_     in   1   reset; synchronous, active-low
//  CE         in   1   one-cycle bus strobe; qualifies CS_/RW/A/DI
//  CS_        in   1   chip select, active-low
//  RW         in   1   1 = read, 0 = write
//  A          in   3   register address
//  DI         in   8   write data
//  DO         out  8   read data; combinational from A and state
//  IRQ_       out  1   interrupt request, active-low
//  BUTTONS    in   8   raw buttons from tm1638_driver; 1 = pressed; asynchronous
//  LEDS       out  8   to tm1638_driver leds
//  DOTS       out  8   to tm1638_driver dots
//  DIGITS     out  56  D0 = [6:0] .. D7 = [55:49], segment bitmaps
// BEHAVIOUR
//  Register map. A bus access is CE & !CS_; writes and pops take effect at that clock edge.
//   0 LEDS  R/W.  1 DOTS  R/W.  2 DSEL  R/W; bits[2:0] digit index, reads {5'b0,sel}.
//   3 DDATA  W: digit[sel] <= DI[6:0], then sel <= sel+1 (7 wraps to 0).
//            R: {1'b0,digit[sel]}; no increment.
//   4 KEYS   R: debounced stable state.
//   5 EVENT  R: returns the FIFO head and pops it; returns 8'hFF if empty (no pop).
//      Event format: bit7 = 1 press / 0 release; bits6:3 = 0; bits2:0 = key index.
//   6 STAT   R: {irq_en,5'b0,ovf,!empty}.
//            W: DI[7] -> irq_en; DI[1]=1 clears ovf (write-one-to-clear).
//   7 rsvd   reads 8'h00; writes ignored.
//   Accesses with CE=0 or CS_=1 change nothing. DO is still driven for the selected A and never pops.
//  Reset (RESET_=0 at an edge):
//   - LEDS, DOTS, DIGITS, sel, irq_en, ovf = 0;
//   - FIFO empty, stable = 0, debounce counters = 0, pending mask = 0;
//   - prescaler = 0; IRQ_ = 1.
//   A reset mid-debounce or mid-serialisation discards all in-flight events.
//  Sync: BUTTONS passes through 2 flops before use.
//  Tick: 1-cycle pulse every SYSCLK_MHZ*1000 clocks.
//  Debounce, per key, on each tick:
//   - if sync != stable: cnt++; when cnt reaches DEBOUNCE_MS, stable flips, cnt <= 0 and the key's pending bit is set;
//   - if sync == stable: cnt <= 0.
//  Serialiser:
//   - each cycle it takes the lowest-index pending bit, pushes {stable[k],4'b0,k} and clears the bit;
//   - at most one push per cycle, so N simultaneous changes take N cycles.
//  FIFO, when a push meets a full FIFO:
//   - the event is dropped, ovf <= 1 and the pending bit is still cleared;
//   - exception: a pop in the same cycle frees the slot and the push is accepted.
//   - push and pop in the same cycle on a non-empty FIFO: count is unchanged, order is preserved.
//   - push into an empty FIFO: readable on the next cycle (1-cycle latency).
//  IRQ_ = !(irq_en & !empty), registered, so it lags the FIFO state by 1 cycle.
// STRUCTURE
//  - Shared include ledkey_defs.vh holds:
//    - register addresses LK_REG_*;
//    - the event bit positions LK_EVT_PRESS = 7;
//    - LK_EVT_EMPTY = 8'hFF.
//  - Sub-module ledkey_evt_fifo: synchronous FIFO (DEPTH, WIDTH=8).
//    Ports push/pop/din/dout/full/empty; dout shows the head.
//  - Top of block: register file, read mux, synchroniser, prescaler, 8 debounce counters, priority serialiser.
// TESTING (SYSCLK_MHZ=1, DEBOUNCE_MS=3 to shorten runs)
//  1. Write LEDS=8'hA5 then read A=0 -> DO=8'hA5, LEDS=8'hA5.
//     Reset -> LEDS=0, DIGITS=0, IRQ_=1.
//  2. DSEL=7; write DDATA 7'h7D then 7'h6D -> D7=7'h7D, D0=7'h6D, DSEL reads 8'h01.
//  3. Hold BUTTONS[2]=1 for 3 ticks -> KEYS=8'h04 and EVENT reads 8'h82.
//     Release for 3 ticks -> EVENT reads 8'h02; the next read returns 8'hFF.
//     A bounce shorter than 3 ticks produces no event.
//  4. BUTTONS 8'h00 -> 8'h81 in one step -> events 8'h80 then 8'h87, in index order.
//     With irq_en=1: IRQ_=0 until both are read, then 1.
//  5. Generate 9 events with no reads (depth 8):
//     - 8 events are queued; STAT reads 8'h03 (irq_en=0, ovf=1, not empty);
//     - write STAT 8'h02 -> ovf clears; 8 events then read out in order.
//  6. Pop on a full FIFO in the same cycle as a new push -> no overflow, count stays 8.
//     Reset mid-debounce with the button held -> one press event ~3 ticks after reset release.

Source files
------------

// File: rtl/ledkey_io_ctrl_pkg.sv
// Shared definitions for the LED&KEY panel controller: register map,
// event encoding and small helpers used by the top and the bench.
package ledkey_io_ctrl_pkg;

  // Register addresses as seen on the 6502 bus
  typedef enum logic [2:0] {
    LK_REG_LEDS  = 3'd0,
    LK_REG_DOTS  = 3'd1,
    LK_REG_DSEL  = 3'd2,
    LK_REG_DDATA = 3'd3,
    LK_REG_KEYS  = 3'd4,
    LK_REG_EVENT = 3'd5,
    LK_REG_STAT  = 3'd6,
    LK_REG_RSVD  = 3'd7
  } lk_reg_e;

  // Event byte: press flag in bit 7, key index in bits 2:0
  localparam int         LK_EVT_PRESS = 7;
  localparam logic [7:0] LK_EVT_EMPTY = 8'hFF;

  // Build an event byte from the new key level and key index
  function automatic logic [7:0] lk_make_event(input logic pressed, input logic [2:0] idx);
    logic [7:0] ev;
    ev               = 8'h00;
    ev[LK_EVT_PRESS] = pressed;
    ev[2:0]          = idx;
    return ev;
  endfunction

  // Index of the lowest set bit (0 when the mask is empty)
  function automatic logic [2:0] lk_lowest_index(input logic [7:0] mask);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ledkey_evt_fifo.sv
// Synchronous key-event FIFO. dout always shows the head entry.
// A push into a full FIFO is accepted only when a pop frees the slot
// in the same cycle; otherwise it is ignored (the caller flags overflow).
module ledkey_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             wr_en_s;
  logic             rd_en_s;

  // Status decode and qualified read/write enables
  always_comb begin
    full    = (count_r == CNT_W'(DEPTH));
    empty   = (count_r == '0);
    dout    = mem_r[rd_ptr_r];
    rd_en_s = pop & ~empty;
    wr_en_s = push & (~full | pop);
  end

  // Storage array write
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ledkey_io_ctrl.sv
// CPU-side controller for the LED&KEY panel: LED/dot/digit registers,
// button synchroniser and debouncer, press/release event queue and IRQ.
module ledkey_io_ctrl
  import ledkey_io_ctrl_pkg::*;
#(
  parameter int SYSCLK_MHZ  = 27,
  parameter int DEBOUNCE_MS = 10,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        CLK,
  input  logic        RESET_,
  input  logic        CE,
  input  logic        CS_,
  input  logic        RW,
  input  logic [2:0]  A,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  output logic        IRQ_,
  input  logic [7:0]  BUTTONS,
  output logic [7:0]  LEDS,
  output logic [7:0]  DOTS,
  output logic [55:0] DIGITS
);

  localparam int         TICK_CYCLES = SYSCLK_MHZ * 1000;
  localparam int         PRE_W       = $clog2(TICK_CYCLES);
  localparam logic [3:0] DB_LAST     = 4'(DEBOUNCE_MS - 1);

  logic [PRE_W-1:0] presc_r;
  logic             tick_s;
  logic [7:0]       sync1_r;
  logic [7:0]       sync2_r;
  logic [7:0]       stable_r;
  logic [3:0]       cnt_r [8];
  logic [7:0]       flip_s;
  logic [7:0]       pending_r;
  logic [7:0]       clear_s;
  logic [2:0]       pend_idx_s;
  logic             push_s;
  logic [7:0]       push_data_s;
  logic             drop_s;
  logic [7:0]       leds_r;
  logic [7:0]       dots_r;
  logic [2:0]       sel_r;
  logic [6:0]       digit_r [8];
  logic             irq_en_r;
  logic             ovf_r;
  logic             irq_n_r;
  logic             acc_s;
  logic             wr_s;
  logic             rd_s;
  logic             pop_s;
  logic [7:0]       fifo_dout_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  // Bus strobe decode; reading EVENT pops only when there is something to pop
  always_comb begin
    acc_s = CE & ~CS_;
    wr_s  = acc_s & ~RW;
    rd_s  = acc_s & RW;
    pop_s = rd_s & (A == LK_REG_EVENT) & ~fifo_empty_s;
  end

  // Millisecond prescaler
  always_ff @(posedge CLK) begin
    if (!RESET_) begin
      presc_r <= '0;
    end else if (presc_r == PRE_W'(TICK_CYCLES - 1)) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRE_W'(1);
    end
  end

  assign tick_s = (presc_r == PRE_W'(TICK_CYCLES - 1));

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge CLK) begin
    if (!RESET_) begin
      sync1_r <= 8'h00;
      sync2_r <= 8'h00;
    end else begin
      sync1_r <= BUTTONS;
      sync2_r <= sync1_r;
    end
  end

  // Keys whose counter completes on this tick flip their stable level
  always_comb begin
    flip_s = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (tick_s && (sync2_r[k] != stable_r[k]) && (cnt_r[k] == DB_LAST)) begin
        flip_s[k] = 1'b1;
      end else begin
        flip_s[k] = 1'b0;
      end
    end
  end

  // Per-key debounce counters and the accepted (stable) key state
  always_ff @(posedge CLK) begin
    if (!RESET_) begin
      stable_r <= 8'h00;
      for (int k = 0; k < 8; k++) begin
        cnt_r[k] <= 4'd0;
      end
    end else begin
      stable_r <= stable_r ^ flip_s;
      if (tick_s) begin
        for (int k = 0; k < 8; k++) begin
          if ((sync2_r[k] != stable_r[k]) && !flip_s[k]) begin
            cnt_r[k] <= cnt_r[k] + 4'd1;
          end else begin
            cnt_r[k] <= 4'd0;
          end
        end
      end
    end
  end

  // Priority serialiser: one pending key per cycle, lowest index first
  always_comb begin
    push_s      = |pending_r;
    pend_idx_s  = lk_lowest_index(pending_r);
    push_data_s = lk_make_event(stable_r[pend_idx_s], pend_idx_s);
    if (push_s) begin
      clear_s = 8'h01 << pend_idx_s;
    end else begin
      clear_s = 8'h00;
    end
    drop_s = push_s & fifo_full_s & ~pop_s;
  end

  // Pending-event mask; a fresh flip always wins over the serialiser clear
  always_ff @(posedge CLK) begin
    if (!RESET_) begin
      pending_r <= 8'h00;
    end else begin
      pending_r <= (pending_r & ~clear_s) | flip_s;
    end
  end

  ledkey_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_data_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // CPU-writable registers; DDATA writes auto-advance the digit select
  always_ff @(posedge CLK) begin
    if (!RESET_) begin
      leds_r   <= 8'h00;
      dots_r   <= 8'h00;
      sel_r    <= 3'd0;
      irq_en_r <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        digit_r[k] <= 7'h00;
      end
    end else if (wr_s) begin
      case (lk_reg_e'(A))
        LK_REG_LEDS:  leds_r <= DI;
        LK_REG_DOTS:  dots_r <= DI;
        LK_REG_DSEL:  sel_r  <= DI[2:0];
        LK_REG_DDATA: begin
          digit_r[sel_r] <= DI[6:0];
          sel_r          <= sel_r + 3'd1;
        end
        LK_REG_STAT:  irq_en_r <= DI[7];
        default: begin
        end
      endcase
    end
  end

  // Sticky overflow flag; a new drop beats a simultaneous clear
  always_ff @(posedge CLK) begin
    if (!RESET_) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (wr_s && (A == LK_REG_STAT) && DI[1]) begin
      ovf_r <= 1'b0;
    end
  end

  // Registered active-low interrupt request
  always_ff @(posedge CLK) begin
    if (!RESET_) begin
      irq_n_r <= 1'b1;
    end else begin
      irq_n_r <= ~(irq_en_r & ~fifo_empty_s);
    end
  end

  // Read data mux
  always_comb begin
    DO = 8'h00;
    case (lk_reg_e'(A))
      LK_REG_LEDS:  DO = leds_r;
      LK_REG_DOTS:  DO = dots_r;
      LK_REG_DSEL:  DO = {5'b00000, sel_r};
      LK_REG_DDATA: DO = {1'b0, digit_r[sel_r]};
      LK_REG_KEYS:  DO = stable_r;
      LK_REG_EVENT: begin
        if (fifo_empty_s) begin
          DO = LK_EVT_EMPTY;
        end else begin
          DO = fifo_dout_s;
        end
      end
      LK_REG_STAT:  DO = {irq_en_r, 5'b00000, ovf_r, ~fifo_empty_s};
      default:      DO = 8'h00;
    endcase
  end

  // Flatten the digit bitmaps onto the driver bus
  always_comb begin
    DIGITS = 56'h0;
    for (int k = 0; k < 8; k++) begin
      DIGITS[k*7 +: 7] = digit_r[k];
    end
  end

  assign LEDS = leds_r;
  assign DOTS = dots_r;
  assign IRQ_ = irq_n_r;

endmodule
